fullchip_dispatch: RTL

//  Next-generation chip front-end: replaces single-core top wiring with a buffered dispatcher to NCORE core instances.

---
 rtl/fullchip_dispatch_pkg.sv | 18 +
 rtl/fullchip_dispatch_sync_fifo.sv | 62 ++++++
 rtl/fullchip_dispatch.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fullchip_dispatch_pkg.sv
// Shared constants and helpers for the chip front-end dispatcher.
//   INST_W / INST_NOP : core instruction width and the idle encoding
//   CNT_W             : width of the free-running statistics counters
//   entry_width()     : packed FIFO entry width {inst, mem, mask}
package fullchip_pkg;

  localparam int unsigned INST_W = 20;
  localparam logic [INST_W-1:0] INST_NOP = 20'h0;
  localparam int unsigned CNT_W = 16;

  // Width of one queued word: instruction, pr*bw data lanes, per-core mask.
  function automatic int unsigned entry_width(input int unsigned pr,
                                              input int unsigned bw,
                                              input int unsigned ncore);
    return INST_W + pr * bw + ncore;
  endfunction

endpackage

// File: rtl/fullchip_dispatch_sync_fifo.sv
// Synchronous FIFO, no fall-through: a pushed word becomes visible at dout
// on the cycle after the push edge.
//   clk, reset       : clock, synchronous active-high reset (flushes queue)
//   push, din        : write request and data (ignored when full)
//   pop              : read request (ignored when empty), dout = head word
//   full, empty      : occupancy flags
//   count            : current occupancy, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; flushing the pointers empties the queue.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/fullchip_dispatch.sv
// Buffered instruction dispatcher feeding NCORE core channels.
// Host words {inst, mem, mask} are queued in a DEPTH-entry FIFO and issued
// in strict order, each word to every core in its mask in the same cycle.
//   clk, reset     : clock, synchronous active-high reset
//   in_valid/ready : host handshake; in_inst, in_mem, in_mask are the word
//   core_stall     : per-core backpressure, blocks the head if any target stalls
//   core_inst      : per-core instruction pulses, slice c = [c*20 +: 20]
//   core_mem_in    : per-core data pulses, slice c = [c*pr*bw +: pr*bw]
//   fifo_count     : queue occupancy
//   issue_cnt      : words issued (non-empty mask), wraps
//   stall_cnt      : cycles the head was blocked, wraps
module fullchip_dispatch
  import fullchip_pkg::*;
#(
  parameter int unsigned col     = 8,
  parameter int unsigned bw      = 8,
  parameter int unsigned bw_psum = 2 * bw + 4,
  parameter int unsigned pr      = 16,
  parameter int unsigned NCORE   = 2,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [INST_W-1:0]           in_inst,
  input  logic [pr*bw-1:0]            in_mem,
  input  logic [NCORE-1:0]            in_mask,
  input  logic [NCORE-1:0]            core_stall,
  output logic [NCORE*INST_W-1:0]     core_inst,
  output logic [NCORE*pr*bw-1:0]      core_mem_in,
  output logic [$clog2(DEPTH):0]      fifo_count,
  output logic [CNT_W-1:0]            issue_cnt,
  output logic [CNT_W-1:0]            stall_cnt
);

  localparam int unsigned MEM_W   = pr * bw;
  localparam int unsigned ENTRY_W = entry_width(pr, bw, NCORE);

  // col and bw_psum only configure the cores; checked here for sanity.
  if (NCORE < 1 || NCORE > 8 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      col < 1 || bw_psum < 2 * bw) begin : g_param_check
    $error("fullchip_dispatch: illegal parameter set");
  end

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [MEM_W-1:0]  mem;
    logic [NCORE-1:0]  mask;
  } entry_t;

  entry_t               w_push_entry;
  entry_t               w_head;
  logic [ENTRY_W-1:0]   w_head_bits;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_eligible;
  logic                 w_blocked;
  logic                 w_issue;
  logic [CNT_W-1:0]     r_issue_cnt;
  logic [CNT_W-1:0]     r_stall_cnt;

  assign in_ready     = !w_full && !reset;
  assign w_push       = in_valid && in_ready;
  assign w_push_entry = '{inst: in_inst, mem: in_mem, mask: in_mask};
  assign w_head       = entry_t'(w_head_bits);

  // Head issues only when every targeted core is free (all-or-nothing).
  // A zero-mask head is never blocked, so it simply drains as a bubble.
  assign w_eligible   = !w_empty;
  assign w_blocked    = |(w_head.mask & core_stall);
  assign w_issue      = w_eligible && !w_blocked;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_issue),
    .din   (w_push_entry),
    .dout  (w_head_bits),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );

  // Per-core output registers: one-cycle pulse of the head word, else NOP.
  for (genvar c = 0; c < NCORE; c++) begin : g_core
    logic [INST_W-1:0] r_inst;
    logic [MEM_W-1:0]  r_mem;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_inst <= INST_NOP;
        r_mem  <= '0;
      end else if (w_issue && w_head.mask[c]) begin
        r_inst <= w_head.inst;
        r_mem  <= w_head.mem;
      end else begin
        r_inst <= INST_NOP;
        r_mem  <= '0;
      end
    end

    assign core_inst[c*INST_W +: INST_W]  = r_inst;
    assign core_mem_in[c*MEM_W +: MEM_W]  = r_mem;
  end

  // Statistics counters; zero-mask bubbles are not counted as issues.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_issue && (w_head.mask != '0)) r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      if (w_eligible && w_blocked)        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign issue_cnt = r_issue_cnt;
  assign stall_cnt = r_stall_cnt;

endmodule
